mult_host_sequencer: RTL and testbench

- Host-side initiator for the multiply-sequence controller.
- Issues a one-cycle `start` pulse, waits for the controller's `Ready` pulse, then reads the result buffer element by element.
- Streams the elements out on a valid/ready interface.
- Sits between the system host and the controller/datapath pair; owns job launch, completion detection, timeout and result readout.

---
 rtl/mult_pkg.sv | 31 +++
 rtl/mult_host_sequencer_if.sv | 19 +
 rtl/mult_host_sequencer_wait_timer.sv | 28 ++
 rtl/mult_host_sequencer.sv | 138 +++++++++++++
 tb/tb_mult_host_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-sequence host and controller.
// State encodings, default sizing and address-width helper.
package mult_pkg;

    localparam int ELEMS_DEF   = 4;
    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_READ   = 3'd3,
        ST_SEND   = 3'd4,
        ST_FIN    = 3'd5,
        ST_CSUM   = 3'd6
    } seq_state_e;

    typedef enum logic [2:0] {
        CT_IDLE  = 3'd0,
        CT_LOAD  = 3'd1,
        CT_MULT  = 3'd2,
        CT_STORE = 3'd3,
        CT_READY = 3'd4
    } ctrl_state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_host_sequencer_if.sv
// Result-word stream between the host sequencer and its consumer.
interface mult_host_sequencer_if import mult_pkg::*; #(
    parameter int W = W_DEF
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/mult_host_sequencer_wait_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
module wait_timer import mult_pkg::*; #(
    parameter int CW   = 6,
    parameter int TERM = 62
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_tc
);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == CW'(TERM));
endmodule

// File: rtl/mult_host_sequencer.sv
// Host-side job launcher and result-buffer reader for the multiply controller.
// Optional trailing checksum word: define MULT_HOST_CHECKSUM_EN.
module mult_host_sequencer import mult_pkg::*; #(
    parameter int ELEMS   = ELEMS_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int AW      = addr_w(ELEMS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    output logic                   start,
    input  logic                   Ready,
    output logic [AW-1:0]          rd_addr,
    input  logic [W-1:0]           rd_data,
    mult_host_sequencer_if.master  m_out,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);
    localparam int CW = addr_w(TIMEOUT);

    seq_state_e   r_state;
    seq_state_e   w_next;
    logic [AW-1:0] r_index;
    logic [W-1:0] r_out_data;
    logic         r_out_last;
    logic         r_err;
    logic         w_tc;
    logic         w_valid;
    logic         w_accept;
    logic         w_last_idx;
`ifdef MULT_HOST_CHECKSUM_EN
    logic [W-1:0] r_sum;
`endif

    // Terminal count two below TIMEOUT: the exit edge lands TIMEOUT cycles after start.
    wait_timer #(
        .CW   (CW),
        .TERM (TIMEOUT - 2)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == ST_LAUNCH),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == ST_WAIT),
        .o_tc       (w_tc)
    );

    assign w_valid    = (r_state == ST_SEND) || (r_state == ST_CSUM);
    assign w_accept   = w_valid && m_out.out_ready;
    assign w_last_idx = (r_index == AW'(ELEMS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (go) w_next = ST_LAUNCH;
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                if (Ready)
                    w_next = ST_READ;
                else if (w_tc)
                    w_next = ST_IDLE;
            end
            ST_READ:   w_next = ST_SEND;
            ST_SEND: begin
                if (w_accept) begin
`ifdef MULT_HOST_CHECKSUM_EN
                    w_next = w_last_idx ? ST_CSUM : ST_READ;
`else
                    w_next = w_last_idx ? ST_FIN : ST_READ;
`endif
                end
            end
            ST_CSUM:   if (w_accept) w_next = ST_FIN;
            ST_FIN:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index    <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_err      <= 1'b0;
`ifdef MULT_HOST_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            if (r_state == ST_IDLE && go)
                r_err <= 1'b0;
            if (r_state == ST_WAIT && !Ready && w_tc)
                r_err <= 1'b1;
            if (r_state == ST_WAIT && Ready)
                r_index <= '0;
            if (r_state == ST_READ) begin
                r_out_data <= rd_data;
`ifdef MULT_HOST_CHECKSUM_EN
                r_out_last <= 1'b0;
`else
                r_out_last <= w_last_idx;
`endif
            end
            if (w_accept)
                r_out_last <= 1'b0;
            if (r_state == ST_SEND && w_accept && !w_last_idx)
                r_index <= r_index + 1'b1;
`ifdef MULT_HOST_CHECKSUM_EN
            if (r_state == ST_LAUNCH)
                r_sum <= '0;
            if (r_state == ST_READ)
                r_sum <= r_sum + rd_data;
            if (r_state == ST_SEND && w_accept && w_last_idx) begin
                r_out_data <= r_sum;
                r_out_last <= 1'b1;
            end
`endif
        end
    end

    assign start           = (r_state == ST_LAUNCH);
    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_FIN);
    assign timeout_err     = r_err;
    assign rd_addr         = r_index;
    assign m_out.out_valid = w_valid;
    assign m_out.out_data  = r_out_data;
    assign m_out.out_last  = r_out_last;
endmodule

// File: tb/tb_mult_host_sequencer.sv
// Self-checking bench for mult_host_sequencer: vector table, random jobs, corner sequences.
module tb_mult_host_sequencer;
    localparam int ELEMS   = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;
`ifdef MULT_HOST_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NW = ELEMS + CS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       Ready = 1'b0;
    logic       start;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] mem [ELEMS];

    mult_host_sequencer_if #(.W(W)) u_if ();

    mult_host_sequencer #(
        .ELEMS   (ELEMS),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .start       (start),
        .Ready       (Ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .m_out       (u_if),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    assign rd_data = mem[rd_addr];
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    typedef struct {
        logic [3:0][7:0] b;
        int              rdly;
        int              stall;
        int              xgo;
        bit              tmo;
        logic [7:0]      esum;
    } vec_t;

    function automatic vec_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int rdly, input int stall,
                                input int xgo, input bit tmo, input int esum);
        vec_t v;
        v.b[0]  = 8'(a0);
        v.b[1]  = 8'(a1);
        v.b[2]  = 8'(a2);
        v.b[3]  = 8'(a3);
        v.rdly  = rdly;
        v.stall = stall;
        v.xgo   = xgo;
        v.tmo   = tmo;
        v.esum  = 8'(esum);
        return v;
    endfunction

    int q_w[$];
    int q_l[$];
    int n_done, n_start, s_cyc, first_v, err_cyc, err_at1, busy_end, hold_bad;

    // One job: go on cycle 0, Ready rdly cycles after start, each word stalled 'stall' cycles.
    task automatic run_job(input int rdly, input int stall, input int xgo, input int ncyc);
        int ctr;
        int held;
        q_w.delete();
        q_l.delete();
        n_done = 0; n_start = 0; s_cyc = -1; first_v = -1;
        err_cyc = -1; err_at1 = -1; hold_bad = 0;
        ctr = 0; held = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk);
            #1;
            go = (cyc == 0) || (cyc == xgo);
            Ready = (s_cyc >= 0) && (rdly > 0) && (cyc == s_cyc + rdly);
            u_if.out_ready = (ctr >= stall);
            @(negedge clk);
            if (start) begin
                n_start++;
                if (s_cyc < 0) s_cyc = cyc;
            end
            if (cyc == 1) err_at1 = int'(timeout_err);
            if (cyc >= 1 && timeout_err && err_cyc < 0) err_cyc = cyc;
            if (done) n_done++;
            if (u_if.out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (ctr > 0 && int'(u_if.out_data) != held) hold_bad++;
                held = int'(u_if.out_data);
                if (u_if.out_ready) begin
                    q_w.push_back(int'(u_if.out_data));
                    q_l.push_back(int'(u_if.out_last));
                    ctr = 0;
                end else begin
                    ctr++;
                end
            end
            busy_end = int'(busy);
        end
        go = 1'b0;
        Ready = 1'b0;
    endtask

    task automatic expect_ok(input string nm, input int rdly,
                             input logic [3:0][7:0] e, input logic [7:0] esum);
        int got, gl, ew;
        chk({nm, ".nwords"}, q_w.size(), NW);
        for (int i = 0; i < NW; i++) begin
            got = (i < q_w.size()) ? q_w[i] : -1;
            gl  = (i < q_l.size()) ? q_l[i] : -1;
            ew  = (i < ELEMS) ? int'(e[i]) : int'(esum);
            chk($sformatf("%s.word%0d", nm, i), got, ew);
            chk($sformatf("%s.last%0d", nm, i), gl, (i == NW - 1) ? 1 : 0);
        end
        chk({nm, ".done"}, n_done, 1);
        chk({nm, ".starts"}, n_start, 1);
        chk({nm, ".start_cyc"}, s_cyc, 1);
        chk({nm, ".first_valid"}, first_v, rdly + 3);
        chk({nm, ".err_clear"}, err_at1, 0);
        chk({nm, ".no_err"}, err_cyc, -1);
        chk({nm, ".hold"}, hold_bad, 0);
        chk({nm, ".busy_end"}, busy_end, 0);
    endtask

    task automatic expect_tmo(input string nm);
        chk({nm, ".nwords"}, q_w.size(), 0);
        chk({nm, ".valid"}, first_v, -1);
        chk({nm, ".done"}, n_done, 0);
        chk({nm, ".starts"}, n_start, 1);
        chk({nm, ".err_clear"}, err_at1, 0);
        chk({nm, ".err_cyc"}, err_cyc, (s_cyc < 0) ? -2 : s_cyc + TIMEOUT);
        chk({nm, ".busy_end"}, busy_end, 0);
        chk({nm, ".sticky"}, int'(timeout_err), 1);
    endtask

    vec_t tbl[8];

    initial begin
        logic [3:0][7:0] e;
        int              sum;
        int              rdly;
        int              stall;
        int              bad;
        bit              seen;

        tbl[0] = mk(3, 5, 7, 9, 10, 0, -1, 0, 24);
        tbl[1] = mk(3, 5, 7, 9, 1, 0, -1, 0, 24);
        tbl[2] = mk(3, 5, 7, 9, 4, 5, -1, 0, 24);
        tbl[3] = mk(200, 100, 3, 4, 63, 1, -1, 0, 51);
        tbl[4] = mk(1, 1, 1, 1, 64, 0, -1, 1, 0);
        tbl[5] = mk(10, 20, 30, 40, 20, 0, 5, 0, 100);
        tbl[6] = mk(1, 1, 1, 1, 0, 0, -1, 1, 0);
        tbl[7] = mk(255, 1, 0, 128, 2, 2, -1, 0, 128);

        u_if.out_ready = 1'b0;
        for (int i = 0; i < ELEMS; i++) mem[i] = 8'h00;

        #2;
        chk("reset.start", int'(start), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.err", int'(timeout_err), 0);
        chk("reset.valid", int'(u_if.out_valid), 0);
        chk("reset.last", int'(u_if.out_last), 0);
        chk("reset.rd_addr", int'(rd_addr), 0);
        chk("reset.data", int'(u_if.out_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Ready while idle must not wake the sequencer
        @(posedge clk); #1 Ready = 1'b1;
        @(posedge clk); #1 Ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy || start || u_if.out_valid) bad++;
        end
        chk("idle_ready.ignored", bad, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < ELEMS; i++) mem[i] = tbl[t].b[i];
            if (tbl[t].tmo) begin
                run_job(tbl[t].rdly, 0, -1, TIMEOUT + 8);
                expect_tmo($sformatf("vec%0d", t));
            end else begin
                run_job(tbl[t].rdly, tbl[t].stall, tbl[t].xgo,
                        tbl[t].rdly + 3 + NW * (2 + tbl[t].stall) + 6);
                expect_ok($sformatf("vec%0d", t), tbl[t].rdly, tbl[t].b, tbl[t].esum);
            end
        end

        // Random jobs against a sum/passthrough model
        for (int r = 0; r < 6; r++) begin
            sum = 0;
            for (int i = 0; i < ELEMS; i++) begin
                mem[i] = 8'($urandom_range(0, 255));
                e[i]   = mem[i];
                sum    = sum + int'(mem[i]);
            end
            rdly  = $urandom_range(1, TIMEOUT - 1);
            stall = $urandom_range(0, 2);
            run_job(rdly, stall, -1, rdly + 3 + NW * (2 + stall) + 6);
            expect_ok($sformatf("rand%0d", r), rdly, e, 8'(sum % 256));
        end

        // Asynchronous reset while a word is being offered
        mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44;
        u_if.out_ready = 1'b0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = start;
        end
        chk("rstmid.start_seen", int'(seen), 1);
        @(posedge clk); #1 Ready = 1'b1;
        @(posedge clk); #1 Ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = u_if.out_valid;
        end
        chk("rstmid.valid_seen", int'(seen), 1);
        chk("rstmid.data_before", int'(u_if.out_data), 11);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.valid", int'(u_if.out_valid), 0);
        chk("rstmid.data", int'(u_if.out_data), 0);
        chk("rstmid.busy", int'(busy), 0);
        chk("rstmid.rd_addr", int'(rd_addr), 0);
        chk("rstmid.start", int'(start), 0);
        chk("rstmid.last", int'(u_if.out_last), 0);
        #1 rst = 1'b0;
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
        for (int i = 0; i < ELEMS; i++) e[i] = mem[i];
        run_job(3, 0, -1, 3 + 3 + NW * 2 + 6);
        expect_ok("after_rst", 3, e, 8'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
